// File: rtl/operand_writeback_stage_if.sv
// Issue-side bundle for the operand/writeback stage: decoded instruction fields plus valid/ready.
// Handshake: a transfer happens on a rising edge where issue_valid && issue_ready; the master holds all fields stable while valid is high and not yet accepted.
interface operand_writeback_stage_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 5,
    parameter int AW     = 3
);
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [AW-1:0]     issue_ra;
    logic [AW-1:0]     issue_rb;
    logic [DATA_W-1:0] issue_imm;
    logic              issue_use_imm;
    logic [AW-1:0]     issue_rd;
    logic              issue_wr_en;
    logic              issue_flag_en;

    modport master (
        output issue_valid, issue_op, issue_ra, issue_rb, issue_imm,
               issue_use_imm, issue_rd, issue_wr_en, issue_flag_en,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_op, issue_ra, issue_rb, issue_imm,
               issue_use_imm, issue_rd, issue_wr_en, issue_flag_en,
        output issue_ready
    );
endinterface

// File: rtl/operand_writeback_stage.sv
// Register file plus a single EX pipeline register feeding a combinational ALU;
// retires results into the file and latches branch flags, with EX-to-issue forwarding.
module operand_writeback_stage #(
    parameter int DATA_W   = 8,
    parameter int OP_W     = 5,
    parameter int NUM_REGS = 8,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    operand_writeback_stage_if.slave issue_if,
    input  logic                 ex_stall,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [OP_W-1:0]      alu_op,
    output logic                 ex_valid,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_equal,
    input  logic                 alu_less,
    output logic                 flag_eq,
    output logic                 flag_lt,
    input  logic [AW-1:0]        dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [OP_W-1:0]   r_ex_op;
    logic [AW-1:0]     r_ex_rd;
    logic              r_ex_wr_en;
    logic              r_ex_flag_en;
    logic              r_flag_eq;
    logic              r_flag_lt;

    logic              w_retire;
    logic              w_accept;
    logic              w_fwd_a;
    logic              w_fwd_b;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    assign w_retire = r_ex_valid && !ex_stall;
    assign issue_if.issue_ready = !r_ex_valid || !ex_stall;
    assign w_accept = issue_if.issue_valid && issue_if.issue_ready;

    // A retiring write lands on the same edge the new operands are captured, so bypass it.
    assign w_fwd_a = w_retire && r_ex_wr_en && (r_ex_rd == issue_if.issue_ra);
    assign w_fwd_b = w_retire && r_ex_wr_en && (r_ex_rd == issue_if.issue_rb);

    always_comb begin
        w_op_a = w_fwd_a ? alu_result : r_regs[issue_if.issue_ra];
        w_op_b = r_regs[issue_if.issue_rb];
        if (issue_if.issue_use_imm) begin
            w_op_b = issue_if.issue_imm;
        end else if (w_fwd_b) begin
            w_op_b = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_ex_valid   <= 1'b0;
            r_ex_a       <= '0;
            r_ex_b       <= '0;
            r_ex_op      <= '0;
            r_ex_rd      <= '0;
            r_ex_wr_en   <= 1'b0;
            r_ex_flag_en <= 1'b0;
            r_flag_eq    <= 1'b0;
            r_flag_lt    <= 1'b0;
        end else begin
            if (w_retire && r_ex_wr_en) begin
                r_regs[r_ex_rd] <= alu_result;
            end
            if (w_retire && r_ex_flag_en) begin
                r_flag_eq <= alu_equal;
                r_flag_lt <= alu_less;
            end
            // Accept implies the slot is empty or retiring; otherwise a stalled EX holds everything.
            if (w_accept) begin
                r_ex_valid   <= 1'b1;
                r_ex_a       <= w_op_a;
                r_ex_b       <= w_op_b;
                r_ex_op      <= issue_if.issue_op;
                r_ex_rd      <= issue_if.issue_rd;
                r_ex_wr_en   <= issue_if.issue_wr_en;
                r_ex_flag_en <= issue_if.issue_flag_en;
            end else if (w_retire) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign alu_a    = r_ex_a;
    assign alu_b    = r_ex_b;
    assign alu_op   = r_ex_op;
    assign ex_valid = r_ex_valid;
    assign flag_eq  = r_flag_eq;
    assign flag_lt  = r_flag_lt;
    assign dbg_data = r_regs[dbg_addr];
endmodule

// File: doc/operand_writeback_stage.md
Name: operand_writeback_stage

Overview:
- Register-file and pipeline stage wrapped around the 8-bit ALU.
- Upstream: accepts decoded issue requests and reads operands (register or immediate), registers them with the opcode, and drives the ALU inputs for one EX cycle.
- Downstream: captures ALU result into the destination register and latches the equal/less flags for branch logic.
- Provides EX-to-issue forwarding and a downstream stall.

Parameters:
- DATA_W, 8, datapath width; must match the ALU.
- OP_W, 5, ALU operation code width.
- NUM_REGS, 8, register count; AW = clog2(NUM_REGS).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  decoded instruction present.
- issue_ready  out  1  stage can accept an issue this cycle.
- issue_op  in  OP_W  ALU operation.
- issue_ra  in  AW  source register A.
- issue_rb  in  AW  source register B.
- issue_imm  in  DATA_W  immediate.
- issue_use_imm  in  1  replace operand B with issue_imm.
- issue_rd  in  AW  destination register.
- issue_wr_en  in  1  write result to issue_rd.
- issue_flag_en  in  1  update flags from this operation.
- ex_stall  in  1  downstream hold request.
- alu_a  out  DATA_W  to ALU inputA.
- alu_b  out  DATA_W  to ALU inputB.
- alu_op  out  OP_W  to ALU operation.
- ex_valid  out  1  EX stage holds a live instruction.
- alu_result  in  DATA_W  from ALU.
- alu_equal  in  1  from ALU.
- alu_less  in  1  from ALU.
- flag_eq  out  1  latched equal flag.
- flag_lt  out  1  latched less flag.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  DATA_W  combinational read of the register file.

Behaviour:
- Reset (sync, active-high, clocked on rising edge):
  - all registers cleared to 0.
  - ex_valid, alu_a, alu_b, alu_op, ex_wr_en, ex_flag_en, flag_eq, flag_lt all cleared to 0.
  - Reset overrides any issue or writeback in the same cycle; an in-flight EX instruction is discarded with no write and no flag update.
- issue_ready = !ex_valid || !ex_stall. Issue is accepted when issue_valid && issue_ready.
- Pipeline:
  - Accept in cycle N -> ex_valid=1 in N+1, with alu_a/alu_b/alu_op registered.
  - ALU is combinational in N+1.
  - Writeback/flag update at the N+1 -> N+2 edge, only if !ex_stall in N+1.
  - Issue-to-register-visible latency is 2 edges.
- Writeback (EX retire when ex_valid && !ex_stall):
  - if ex_wr_en: regs[ex_rd] <= alu_result.
  - if ex_flag_en: flag_eq <= alu_equal, flag_lt <= alu_less. Otherwise flags hold.
- EX register update:
  - retire && issue accepted -> load new instruction.
  - retire && no issue -> ex_valid <= 0; data registers may hold.
  - ex_valid && ex_stall -> all EX registers hold; alu_* outputs stable.
  - !ex_valid && !issue -> ex_valid stays 0.
- Operand read, combinational at issue:
  - opA = regs[issue_ra].
  - opB = issue_use_imm ? issue_imm : regs[issue_rb].
- Forwarding: if the EX instruction retires in the same cycle with ex_wr_en and ex_rd matches a register source, that source takes alu_result instead of the file value. The immediate path is never forwarded. The A and B checks are independent; both may forward.
- No writeback occurs in a stall cycle, so no issue is accepted then and no forwarding is needed in stalls.
- Flags are visible one cycle after retire; a back-to-back consumer sees the old flags.
- dbg_data = regs[dbg_addr], unaffected by the pending write in that cycle.
- Address widths wrap naturally; NUM_REGS must be a power of 2.

Test Plan:
- Reset, then dbg read of all regs -> all 0; flag_eq=flag_lt=0; ex_valid=0; issue_ready=1.
- Issue op=ADD(00100), use_imm, imm=5, ra=0, rd=1, with the ALU model attached -> next cycle alu_a=0, alu_b=5, ex_valid=1; after next edge dbg r1=5.
- Back-to-back: r1=5, then issue r2=r1+r1 the cycle after r1's write issue -> forwarded alu_a=alu_b=5; r2=10.
- ex_stall held 3 cycles with ex_valid=1 -> issue_ready=0, alu_* stable, no register/flag change; on release, retire occurs and the pending issue is accepted that same cycle.
- SUB with flag_en, a=3, b=7 -> flag_lt=1, flag_eq=0; next op without flag_en -> flags unchanged.
- Reset asserted while ex_valid=1 with wr_en to r3 (old value 9) -> r3=0, no write of alu_result, ex_valid=0 next cycle.
